// File: rtl/harmonic_voice_scheduler.sv
// -----------------------------------------------------------------------------
// harmonic_voice_scheduler
//
// Shares one combinational quarter-wave sine LUT among NV harmonic voices of a
// piano note. Voice k+1 (slot k) runs at (k+1) x the base frequency and is
// mixed in with weight 2^-k. A frame is NV+1 cycles long:
//   SLOT k (k = 0..NV-1) : present acc_k[31:24] to the LUT and accumulate
//                          (lut_sin - MID) >>> k into the running sum
//   UPDATE               : register the mixed sample, advance all phase
//                          accumulators, clear the sum
// Every frame ends in one sample_valid pulse, so the sample rate is exactly
// f_clk/(NV+1) with no stalls.
//
// Ports
//   clk          system clock
//   rst          synchronous, active-high reset
//   gate         1 = note sounding; 0 = silence with phases held at 0
//                (only looked at in the UPDATE cycle)
//   tune_word    base (fundamental) phase increment per frame
//   tune_load    1-cycle strobe capturing tune_word as the pending base
//   lut_phase    phase presented to the shared LUT (0 during UPDATE)
//   lut_sin      LUT result, offset binary, combinational from lut_phase
//   sample_out   mixed sample, offset binary, midscale MID
//   sample_valid 1-cycle pulse in the cycle sample_out takes a new value
//   slot         active slot 0..NV-1 during SLOT, NV during UPDATE
//
// Parameters
//   NV   number of voices, legal 2..8
//   MID  LUT midscale, also the silent output code
// -----------------------------------------------------------------------------
module harmonic_voice_scheduler #(
  parameter int         NV  = 4,
  parameter logic [9:0] MID = 10'd511
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        gate,
  input  logic [31:0] tune_word,
  input  logic        tune_load,
  output logic [7:0]  lut_phase,
  input  logic [9:0]  lut_sin,
  output logic [9:0]  sample_out,
  output logic        sample_valid,
  output logic [2:0]  slot
);

  typedef enum logic {
    ST_SLOT   = 1'b0,
    ST_UPDATE = 1'b1
  } state_t;

  state_t             state;
  // The UPDATE cycle is identified by the state, not by the slot value, so
  // the 3-bit counter is sufficient even for NV = 8 (where NV wraps to 0).
  logic [2:0]         slot_q;
  logic [31:0]        acc [NV];
  logic [31:0]        pending;
  logic signed [12:0] sum;

  // Combinational datapath signals
  logic signed [12:0] s_ext;
  logic signed [12:0] term;
  logic signed [12:0] mix;
  logic [9:0]         mix_clamped;
  logic [31:0]        base_eff;

  // ---------------------------------------------------------------------------
  // (k+1) x base via shift-add; result kept to 32 bits so the phase wraps.
  // ---------------------------------------------------------------------------
  function automatic logic [31:0] harmonic_inc(input logic [31:0] base,
                                               input logic [3:0]  mult);
    logic [31:0] r;
    r = '0;
    for (int b = 0; b < 4; b++) begin
      if (mult[b]) r = r + (base << b);
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // LUT address: phase of the voice owning the current slot.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path through
    // the block leaves it unassigned, which would infer a latch.
    lut_phase = '0;
    if (state == ST_SLOT) begin
      for (int k = 0; k < NV; k++) begin
        if (slot_q == 3'(k)) lut_phase = acc[k][31:24];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Mixing arithmetic.
  // s = lut_sin - MID is signed -511..+512; the voice weight 2^-k is an
  // arithmetic shift by the slot index (floor toward -inf for negatives).
  // ---------------------------------------------------------------------------
  always_comb begin
    s_ext = $signed({3'b000, lut_sin}) - $signed({3'b000, MID});
    term  = s_ext >>> slot_q;
    mix   = $signed({3'b000, MID}) + (sum >>> 1);
    if (mix < 13'sd0) begin
      mix_clamped = 10'd0;
    end else if (mix > 13'sd1023) begin
      mix_clamped = 10'd1023;
    end else begin
      mix_clamped = mix[9:0];
    end
  end

  // The base applied at UPDATE: a strobe in that very cycle takes effect
  // immediately, otherwise the last captured word. Phases only move at
  // UPDATE, so this value is the one and only base a frame ever sees and no
  // separate copy of it needs to be held.
  assign base_eff = tune_load ? tune_word : pending;

  assign slot = slot_q;

  // ---------------------------------------------------------------------------
  // Frame sequencer and all state.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_SLOT;
      slot_q       <= '0;
      pending      <= '0;
      sum          <= '0;
      sample_out   <= MID;
      sample_valid <= 1'b0;
      // NOTE: the accumulator array is only NV flops wide, not a RAM, and the
      // note must restart from phase 0 after reset, so it is reset explicitly.
      for (int k = 0; k < NV; k++) acc[k] <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // read in this block sees the value from before the clock edge.
      sample_valid <= 1'b0;
      if (tune_load) pending <= tune_word;

      case (state)
        ST_SLOT: begin
          sum <= sum + term;
          if (slot_q == 3'(NV - 1)) begin
            state  <= ST_UPDATE;
            slot_q <= 3'(NV);
          end else begin
            slot_q <= slot_q + 3'd1;
          end
        end

        ST_UPDATE: begin
          sample_valid <= 1'b1;
          sum          <= '0;
          state        <= ST_SLOT;
          slot_q       <= '0;
          if (gate) begin
            sample_out <= mix_clamped;
            for (int k = 0; k < NV; k++) begin
              acc[k] <= acc[k] + harmonic_inc(base_eff, 4'(k + 1));
            end
          end else begin
            sample_out <= MID;
            for (int k = 0; k < NV; k++) acc[k] <= '0;
          end
        end

        default: begin
          state  <= ST_SLOT;
          slot_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_harmonic_voice_scheduler.sv
// -----------------------------------------------------------------------------
// tb_harmonic_voice_scheduler
//
// Directed bench for harmonic_voice_scheduler with NV = 4. The LUT is modelled
// either as a forced constant or as lut_sin = 511 + phase, which makes the
// per-voice signed term equal to the phase byte and keeps expected mixes easy
// to work out by hand. Inputs change #1 after a rising edge; outputs are
// sampled at the same point.
// -----------------------------------------------------------------------------
module tb_harmonic_voice_scheduler;

  logic        clk;
  logic        rst;
  logic        gate;
  logic [31:0] tune_word;
  logic        tune_load;
  logic [7:0]  lut_phase;
  logic [9:0]  lut_sin;
  logic [9:0]  sample_out;
  logic        sample_valid;
  logic [2:0]  slot;

  logic        force_en;
  logic [9:0]  force_val;

  int n_checks = 0;
  int n_errors = 0;

  harmonic_voice_scheduler #(.NV(4), .MID(10'd511)) dut (
    .clk          (clk),
    .rst          (rst),
    .gate         (gate),
    .tune_word    (tune_word),
    .tune_load    (tune_load),
    .lut_phase    (lut_phase),
    .lut_sin      (lut_sin),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .slot         (slot)
  );

  // LUT model: combinational response to lut_phase.
  assign lut_sin = force_en ? force_val : (10'd511 + {2'b00, lut_phase});

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance until sample_valid, bounded; returns the number of edges taken.
  task automatic wait_valid(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!sample_valid && n < 20);
  endtask

  task automatic frame();
    repeat (5) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    logic [31:0] exp_acc;

    rst       = 1'b1;
    gate      = 1'b0;
    tune_word = '0;
    tune_load = 1'b0;
    force_en  = 1'b1;
    force_val = 10'd511;

    // ---------------- Reset state ----------------
    repeat (3) tick();
    check("rst_sample_out", 32'(sample_out), 32'd511);
    check("rst_slot", 32'(slot), 32'd0);
    check("rst_valid", 32'(sample_valid), 32'd0);
    check("rst_lut_phase", 32'(lut_phase), 32'd0);
    rst  = 1'b0;
    gate = 1'b1;
    wait_valid(n);
    check("first_valid_latency", 32'(n), 32'd5);
    check("idle_sample", 32'(sample_out), 32'd511);

    // ---------------- Cadence and mix math ----------------
    force_val = 10'd1022;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("slot_seq_%0d", i), 32'(slot), 32'((i + 1) % 5));
      check($sformatf("valid_seq_%0d", i), 32'(sample_valid), (i == 4) ? 32'd1 : 32'd0);
    end
    // +511 + 255 + 127 + 63 = 956 -> 511 + 478
    check("mix_pos", 32'(sample_out), 32'd989);

    force_val = 10'd0;
    frame();
    check("mix_neg_valid", 32'(sample_valid), 32'd1);
    // -511 - 256 - 128 - 64 = -959 -> 511 - 480
    check("mix_neg", 32'(sample_out), 32'd31);

    force_val = 10'd1023;
    frame();
    // +512 + 256 + 128 + 64 = 960 -> 511 + 480
    check("mix_max", 32'(sample_out), 32'd991);

    // ---------------- Mid-frame reset ----------------
    repeat (2) tick();
    rst = 1'b1;
    repeat (3) tick();
    check("midrst_sample_out", 32'(sample_out), 32'd511);
    check("midrst_slot", 32'(slot), 32'd0);
    check("midrst_valid", 32'(sample_valid), 32'd0);
    rst = 1'b0;
    wait_valid(n);
    check("midrst_latency", 32'(n), 32'd5);
    check("midrst_clean_sum", 32'(sample_out), 32'd991);

    // ---------------- Phase increments at 261.63 Hz ----------------
    force_en  = 1'b0;
    tune_word = 32'd468205;
    tune_load = 1'b1;
    tick();
    tune_load = 1'b0;
    repeat (4) tick();
    check("c4_valid", 32'(sample_valid), 32'd1);
    check("c4_acc0_f1", dut.acc[0], 32'd468205);
    check("c4_acc3_f1", dut.acc[3], 32'd1872820);
    check("c4_sample_f1", 32'(sample_out), 32'd511);
    frame();
    check("c4_acc0_f2", dut.acc[0], 32'd936410);
    check("c4_acc3_f2", dut.acc[3], 32'd3745640);

    // ---------------- Tuning timing ----------------
    // Two strobes mid-frame: the second must win at the next UPDATE.
    tune_word = 32'h0100_0000;
    tune_load = 1'b1;
    tick();
    tune_load = 1'b0;
    tick();
    tune_word = 32'h0200_0000;
    tune_load = 1'b1;
    tick();
    tune_load = 1'b0;
    tune_word = 32'hDEAD_BEEF;
    check("tune_mid_old_phase", 32'(lut_phase), 32'h00);
    tick();
    tick();
    check("tune_mid_sample", 32'(sample_out), 32'd511);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("tune_last_wins_ph%0d", k), 32'(lut_phase), 32'(2 * (k + 1)));
      tick();
    end
    check("update_slot", 32'(slot), 32'd4);
    check("update_lut_phase", 32'(lut_phase), 32'd0);
    // Strobe in the UPDATE cycle applies in that same UPDATE.
    tune_word = 32'h1000_0000;
    tune_load = 1'b1;
    tick();
    tune_load = 1'b0;
    tune_word = 32'hDEAD_BEEF;
    check("tune_phases_valid", 32'(sample_valid), 32'd1);
    // phases 2,4,6,8 -> 2 + 2 + 1 + 1 = 6 -> 511 + 3
    check("tune_phases_sample", 32'(sample_out), 32'd514);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("tune_in_update_ph%0d", k), 32'(lut_phase), 32'(18 * (k + 1)));
      tick();
    end
    tick();
    // phases 18,36,54,72 -> 18 + 18 + 13 + 9 = 58 -> 511 + 29
    check("tune_update_sample", 32'(sample_out), 32'd540);

    // ---------------- Gate ----------------
    gate = 1'b0;
    frame();
    check("gate_off_valid", 32'(sample_valid), 32'd1);
    check("gate_off_sample", 32'(sample_out), 32'd511);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("gate_off_acc%0d", k), dut.acc[k], 32'd0);
    end
    check("gate_off_phase", 32'(lut_phase), 32'd0);
    gate = 1'b1;
    frame();
    check("gate_on_first_sample", 32'(sample_out), 32'd511);
    // A mid-frame gate glitch must be ignored.
    for (int k = 0; k < 4; k++) begin
      check($sformatf("gate_on_ph%0d", k), 32'(lut_phase), 32'(16 * (k + 1)));
      gate = (k == 1) ? 1'b0 : 1'b1;
      tick();
    end
    tick();
    // phases 16,32,48,64 -> 16 + 16 + 12 + 8 = 52 -> 511 + 26
    check("gate_on_resume", 32'(sample_out), 32'd537);

    // ---------------- Phase wrap ----------------
    gate      = 1'b0;
    tune_word = 32'h8000_0000;
    tune_load = 1'b1;
    tick();
    tune_load = 1'b0;
    repeat (4) tick();
    check("wrap_cleared", dut.acc[0], 32'd0);
    gate = 1'b1;
    check("wrap_ph_a", 32'(lut_phase), 32'h00);
    frame();
    check("wrap_sample_a", 32'(sample_out), 32'd511);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("wrap_ph_b%0d", k), 32'(lut_phase), (k % 2 == 0) ? 32'h80 : 32'h00);
      tick();
    end
    tick();
    // phases 128,0,128,0 -> 128 + 0 + 32 + 0 = 160 -> 511 + 80
    check("wrap_sample_b", 32'(sample_out), 32'd591);
    exp_acc = 32'd0;
    check("wrap_acc0", dut.acc[0], exp_acc);
    check("wrap_ph_c", 32'(lut_phase), 32'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
